// File: rtl/test_cpu_if.sv
// Execute-core bus: the instruction stream in, and the writeback/debug view out.
interface test_cpu_if;
   logic [31:0] instruction;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;
   logic [31:0] pc;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        illegal;

   // No handshake: one instruction is consumed on every rising clock edge.
   modport master (
      output instruction, dbg_addr,
      input  dbg_data, pc, wb_en, wb_addr, wb_data, illegal
   );
   modport slave (
      input  instruction, dbg_addr,
      output dbg_data, pc, wb_en, wb_addr, wb_data, illegal
   );
endinterface

// File: rtl/test_cpu.sv
// Single-cycle RV32I integer execute core: decodes the presented instruction,
// computes its result combinationally and writes it back at the rising edge.
module test_cpu #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic      clock,
   input  logic      reset_n,
   test_cpu_if.slave bus
);
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   logic [31:0] regs [32];
   logic [31:0] pc_q;
   logic [6:0]  opcode;
   logic [6:0]  funct7;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  shamt;
   logic [31:0] imm_i;
   logic [31:0] imm_u;
   logic [31:0] src1;
   logic [31:0] src2;
   logic [31:0] operand;
   logic [31:0] result;
   logic        is_op;
   logic        legal;
   logic        wb_en;

   assign opcode = bus.instruction[6:0];
   assign rd     = bus.instruction[11:7];
   assign funct3 = bus.instruction[14:12];
   assign rs1    = bus.instruction[19:15];
   assign rs2    = bus.instruction[24:20];
   assign funct7 = bus.instruction[31:25];
   assign imm_i  = {{20{bus.instruction[31]}}, bus.instruction[31:20]};
   assign imm_u  = {bus.instruction[31:12], 12'b0};

   assign src1 = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
   assign src2 = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

   // OP and OP-IMM share one ALU; only the second operand differs.
   assign is_op   = (opcode == OPC_OP);
   assign operand = is_op ? src2 : imm_i;
   assign shamt   = operand[4:0];

   always_comb begin
      result = 32'd0;
      legal  = 1'b0;
      case (opcode)
         OPC_OP_IMM, OPC_OP: begin
            case (funct3)
               3'b000: begin
                  result = (is_op && funct7 == F7_ALT) ? src1 - operand : src1 + operand;
                  legal  = !is_op || funct7 == F7_BASE || funct7 == F7_ALT;
               end
               3'b001: begin
                  result = src1 << shamt;
                  legal  = (funct7 == F7_BASE);
               end
               3'b010: begin
                  result = {31'd0, $signed(src1) < $signed(operand)};
                  legal  = !is_op || funct7 == F7_BASE;
               end
               3'b011: begin
                  result = {31'd0, src1 < operand};
                  legal  = !is_op || funct7 == F7_BASE;
               end
               3'b100: begin
                  result = src1 ^ operand;
                  legal  = !is_op || funct7 == F7_BASE;
               end
               3'b101: begin
                  result = (funct7 == F7_ALT) ? 32'($signed(src1) >>> shamt) : src1 >> shamt;
                  legal  = (funct7 == F7_BASE) || (funct7 == F7_ALT);
               end
               3'b110: begin
                  result = src1 | operand;
                  legal  = !is_op || funct7 == F7_BASE;
               end
               3'b111: begin
                  result = src1 & operand;
                  legal  = !is_op || funct7 == F7_BASE;
               end
            endcase
         end
         OPC_LUI: begin
            result = imm_u;
            legal  = 1'b1;
         end
         OPC_AUIPC: begin
            result = pc_q + imm_u;
            legal  = 1'b1;
         end
         default: begin
            result = 32'd0;
            legal  = 1'b0;
         end
      endcase
   end

   assign wb_en        = legal && (rd != 5'd0);
   assign bus.wb_en    = wb_en;
   assign bus.wb_addr  = rd;
   assign bus.wb_data  = result;
   assign bus.illegal  = !legal;
   assign bus.pc       = pc_q;
   assign bus.dbg_data = (bus.dbg_addr == 5'd0) ? 32'd0 : regs[bus.dbg_addr];

   // x0 is cleared on reset and never written, so it stays zero in the array too.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_q + 32'd4;
         if (wb_en) regs[rd] <= result;
      end
   end
endmodule

// File: tb/tb_test_cpu.sv
// Bench for test_cpu: directed bring-up sequence plus random instructions
// checked every cycle against a mnemonic-level reference model.
module tb_test_cpu;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   localparam int K_ADDI = 0,  K_SLTI = 1,  K_SLTIU = 2, K_XORI = 3,  K_ORI = 4;
   localparam int K_ANDI = 5,  K_SLLI = 6,  K_SRLI = 7,  K_SRAI = 8,  K_ADD = 9;
   localparam int K_SUB = 10,  K_SLL = 11,  K_SLT = 12,  K_SLTU = 13, K_XOR = 14;
   localparam int K_OR = 15,   K_AND = 16,  K_SRL = 17,  K_SRA = 18,  K_LUI = 19;
   localparam int K_AUIPC = 20, K_ILL_LOAD = 21, K_ILL_F7 = 22, K_ILL_SHF7 = 23;
   localparam int K_ILL_BRANCH = 24, K_LAST = 24;

   localparam logic [6:0] OPI = 7'b0010011;
   localparam logic [6:0] OPR = 7'b0110011;

   logic clock;
   logic reset_n;

   test_cpu_if bus ();

   test_cpu #(.RESET_PC(RESET_PC)) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
   );

   // ---------------- clock ----------------
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // ---------------- model state and scoreboard ----------------
   logic [31:0] mregs [32];
   logic [31:0] mpc;
   bit          check_en;
   bit          exp_legal;
   logic [4:0]  exp_rd;
   logic [31:0] exp_data;
   logic [31:0] exp_dbg;
   logic [31:0] exp_pc;
   int          errors;
   int          checks;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] enc(input int kind, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [31:0] imm);
      case (kind)
         K_ADDI:       return {imm[11:0], rs1, 3'd0, rd, OPI};
         K_SLTI:       return {imm[11:0], rs1, 3'd2, rd, OPI};
         K_SLTIU:      return {imm[11:0], rs1, 3'd3, rd, OPI};
         K_XORI:       return {imm[11:0], rs1, 3'd4, rd, OPI};
         K_ORI:        return {imm[11:0], rs1, 3'd6, rd, OPI};
         K_ANDI:       return {imm[11:0], rs1, 3'd7, rd, OPI};
         K_SLLI:       return {7'h00, imm[4:0], rs1, 3'd1, rd, OPI};
         K_SRLI:       return {7'h00, imm[4:0], rs1, 3'd5, rd, OPI};
         K_SRAI:       return {7'h20, imm[4:0], rs1, 3'd5, rd, OPI};
         K_ADD:        return {7'h00, rs2, rs1, 3'd0, rd, OPR};
         K_SUB:        return {7'h20, rs2, rs1, 3'd0, rd, OPR};
         K_SLL:        return {7'h00, rs2, rs1, 3'd1, rd, OPR};
         K_SLT:        return {7'h00, rs2, rs1, 3'd2, rd, OPR};
         K_SLTU:       return {7'h00, rs2, rs1, 3'd3, rd, OPR};
         K_XOR:        return {7'h00, rs2, rs1, 3'd4, rd, OPR};
         K_OR:         return {7'h00, rs2, rs1, 3'd6, rd, OPR};
         K_AND:        return {7'h00, rs2, rs1, 3'd7, rd, OPR};
         K_SRL:        return {7'h00, rs2, rs1, 3'd5, rd, OPR};
         K_SRA:        return {7'h20, rs2, rs1, 3'd5, rd, OPR};
         K_LUI:        return {imm[19:0], rd, 7'b0110111};
         K_AUIPC:      return {imm[19:0], rd, 7'b0010111};
         K_ILL_LOAD:   return {imm[11:0], rs1, 3'd2, rd, 7'b0000011};
         K_ILL_F7:     return {7'h01, rs2, rs1, 3'd0, rd, OPR};
         K_ILL_SHF7:   return {7'h20, imm[4:0], rs1, 3'd1, rd, OPI};
         default:      return {7'h00, rs2, rs1, 3'd0, rd, 7'b1100011};
      endcase
   endfunction

   // Architectural meaning of each mnemonic; a/b are register values, imm is raw.
   function automatic logic [31:0] model(input int kind, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] imm,
                                         input logic [31:0] pc);
      logic [31:0] si;
      logic [31:0] u;
      si = {{20{imm[11]}}, imm[11:0]};
      u  = {imm[19:0], 12'b0};
      case (kind)
         K_ADDI:  return a + si;
         K_SLTI:  return ($signed(a) < $signed(si)) ? 32'd1 : 32'd0;
         K_SLTIU: return (a < si) ? 32'd1 : 32'd0;
         K_XORI:  return a ^ si;
         K_ORI:   return a | si;
         K_ANDI:  return a & si;
         K_SLLI:  return a << imm[4:0];
         K_SRLI:  return a >> imm[4:0];
         K_SRAI:  return 32'($signed(a) >>> imm[4:0]);
         K_ADD:   return a + b;
         K_SUB:   return a - b;
         K_SLL:   return a << b[4:0];
         K_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         K_SLTU:  return (a < b) ? 32'd1 : 32'd0;
         K_XOR:   return a ^ b;
         K_OR:    return a | b;
         K_AND:   return a & b;
         K_SRL:   return a >> b[4:0];
         K_SRA:   return 32'($signed(a) >>> b[4:0]);
         K_LUI:   return u;
         K_AUIPC: return pc + u;
         default: return 32'd0;
      endcase
   endfunction

   // ---------------- driver tasks ----------------
   // Called shortly after a rising edge; the compare process samples at the falling edge.
   task automatic issue(input int kind, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
      bus.instruction = enc(kind, rd, rs1, rs2, imm);
      bus.dbg_addr    = 5'($urandom_range(0, 31));
      exp_legal = (kind < K_ILL_LOAD);
      exp_rd    = rd;
      exp_data  = model(kind, mregs[rs1], mregs[rs2], imm, mpc);
      exp_dbg   = mregs[bus.dbg_addr];
      exp_pc    = mpc;
      check_en  = 1'b1;
      @(posedge clock);
      check_en = 1'b0;
      if (exp_legal && rd != 5'd0) mregs[rd] = exp_data;
      mpc = mpc + 32'd4;
      #1;
   endtask

   task automatic check_reg(input logic [4:0] addr, input logic [31:0] lit);
      bus.dbg_addr = addr;
      #1;
      check($sformatf("x%0d", addr), bus.dbg_data, lit);
      check($sformatf("model_x%0d", addr), mregs[addr], lit);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      mpc = RESET_PC;
   endtask

   task automatic random_burst(input int n);
      for (int i = 0; i < n; i++) begin
         issue($urandom_range(0, K_LAST), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), $urandom);
      end
   endtask

   // ---------------- compare process ----------------
   always @(negedge clock) begin
      if (check_en) begin
         check("illegal", {31'd0, bus.illegal}, {31'd0, !exp_legal});
         check("wb_en", {31'd0, bus.wb_en}, {31'd0, exp_legal && exp_rd != 5'd0});
         check("wb_addr", {27'd0, bus.wb_addr}, {27'd0, exp_rd});
         if (exp_legal) check("wb_data", bus.wb_data, exp_data);
         check("pc", bus.pc, exp_pc);
         check("dbg_data", bus.dbg_data, exp_dbg);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      errors          = 0;
      checks          = 0;
      check_en        = 1'b0;
      reset_n         = 1'b0;
      bus.instruction = 32'h0000_0013;
      bus.dbg_addr    = 5'd0;
      model_reset();

      repeat (2) @(posedge clock);
      #1;
      check("reset_pc", bus.pc, RESET_PC);
      check_reg(5'd5, 32'd0);
      reset_n = 1'b1;

      // Bring-up sequence with hand-computed values.
      issue(K_ADDI, 5'd5, 5'd6, 5'd0, 32'd7);
      check("pc_after_one", bus.pc, 32'd4);
      check_reg(5'd5, 32'd7);
      check_reg(5'd6, 32'd0);
      issue(K_ADDI, 5'd6, 5'd0, 5'd0, 32'hFFF);
      check_reg(5'd6, 32'hFFFF_FFFF);
      issue(K_ADD, 5'd7, 5'd5, 5'd6, 32'd0);
      check_reg(5'd7, 32'd6);
      issue(K_SUB, 5'd8, 5'd5, 5'd6, 32'd0);
      check_reg(5'd8, 32'd8);
      issue(K_SRAI, 5'd9, 5'd6, 5'd0, 32'd4);
      check_reg(5'd9, 32'hFFFF_FFFF);
      issue(K_SRLI, 5'd10, 5'd6, 5'd0, 32'd28);
      check_reg(5'd10, 32'h0000_000F);
      issue(K_SLT, 5'd11, 5'd6, 5'd5, 32'd0);
      check_reg(5'd11, 32'd1);
      issue(K_SLTU, 5'd12, 5'd6, 5'd5, 32'd0);
      check_reg(5'd12, 32'd0);
      issue(K_LUI, 5'd13, 5'd0, 5'd0, 32'h12345);
      check_reg(5'd13, 32'h1234_5000);
      issue(K_AUIPC, 5'd14, 5'd0, 5'd0, 32'd1);
      check_reg(5'd14, 32'h0000_1024);

      // Write to x0 and an unsupported opcode.
      bus.instruction = enc(K_ADDI, 5'd0, 5'd0, 5'd0, 32'd5);
      #1;
      check("x0_wb_en", {31'd0, bus.wb_en}, 32'd0);
      issue(K_ADDI, 5'd0, 5'd0, 5'd0, 32'd5);
      check_reg(5'd0, 32'd0);
      bus.instruction = enc(K_ILL_LOAD, 5'd15, 5'd0, 5'd0, 32'd0);
      #1;
      check("load_illegal", {31'd0, bus.illegal}, 32'd1);
      issue(K_ILL_LOAD, 5'd15, 5'd0, 5'd0, 32'd0);
      check_reg(5'd15, 32'd0);

      random_burst(400);

      // Asynchronous reset between edges, held across an edge with a writing instruction.
      issue(K_ADDI, 5'd5, 5'd0, 5'd0, 32'h123);
      reset_n = 1'b0;
      model_reset();
      #1;
      check("async_reset_pc", bus.pc, RESET_PC);
      check_reg(5'd5, 32'd0);
      check_reg(5'd13, 32'd0);
      bus.instruction = enc(K_ADDI, 5'd5, 5'd0, 5'd0, 32'd7);
      @(posedge clock);
      #1;
      check("held_reset_pc", bus.pc, RESET_PC);
      check_reg(5'd5, 32'd0);
      reset_n = 1'b1;
      issue(K_ADDI, 5'd5, 5'd0, 5'd0, 32'd7);
      check("pc_after_reset", bus.pc, 32'd4);
      check_reg(5'd5, 32'd7);

      random_burst(200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
